// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: command codes, FSM states
// and the cycle-counter sizing helper.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Counter loads (cycles-1), so clog2(max) bits suffice; never narrower than 1.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int m;
        int w;
        m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int CNT_W = cnt_width(DEF_MULT_CYCLES, DEF_DIV_CYCLES);

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide result from latched operands.
// Optional MD_DIV0_HOLD_EN: divide by zero leaves HI/LO untouched (wr=0).
module md_compute
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        wr
);

    function automatic logic [63:0] mul_signed(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] px;
        logic signed [63:0] py;
        logic signed [63:0] p;
        px = {{32{x[31]}}, x};
        py = {{32{y[31]}}, y};
        p  = px * py;
        return p;
    endfunction

    // Returns {remainder, quotient}; INT_MIN / -1 is pinned to avoid overflow.
    function automatic logic [63:0] div_signed(input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            return {32'h0, 32'h8000_0000};
        end
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {x % y, x / y};
    endfunction

    always_comb begin
        res = '0;
        wr  = 1'b0;
        case (op)
            MD_MULT: begin
                res = mul_signed(a, b);
                wr  = 1'b1;
            end
            MD_MULTU: begin
                res = {32'h0, a} * {32'h0, b};
                wr  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                if (b == '0) begin
`ifdef MD_DIV0_HOLD_EN
                    res = '0;
                    wr  = 1'b0;
`else
                    res = {a, 32'hFFFF_FFFF};
                    wr  = 1'b1;
`endif
                end else begin
                    res = (op == MD_DIV) ? div_signed(a, b) : div_unsigned(a, b);
                    wr  = 1'b1;
                end
            end
            default: begin
                res = '0;
                wr  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO.
// Build option MD_DIV0_HOLD_EN selects divide-by-zero hold behaviour in md_compute.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state;
    md_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    md_op_e           op_p0;
    logic [31:0]      a_p0;
    logic [31:0]      b_p0;
    logic [63:0]      res;
    logic             res_wr;
    logic             accept;
    logic             is_div;
    logic             mt_hi;
    logic             mt_lo;
    logic             done;

    always_comb begin
        is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
        accept = (state == IDLE) && start &&
                 ((md_op == MD_MULT) || (md_op == MD_MULTU) || is_div);
        mt_hi  = (state == IDLE) && start && (md_op == MD_MTHI);
        mt_lo  = (state == IDLE) && start && (md_op == MD_MTLO);
        done   = (state == RUN) && (cnt == '0);
    end

    md_compute u_compute (
        .op  (op_p0),
        .a   (a_p0),
        .b   (b_p0),
        .res (res),
        .wr  (res_wr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Operand latch / countdown stage, then HI/LO commit on the final busy cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_p0 <= MD_MULT;
            a_p0  <= '0;
            b_p0  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                a_p0  <= A;
                b_p0  <= B;
                op_p0 <= md_op_e'(md_op);
                cnt   <= is_div ? DIV_LAST : MULT_LAST;
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (done && res_wr) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end else begin
                if (mt_hi) hi <= A;
                if (mt_lo) lo <= A;
            end
        end
    end

endmodule
